// File: rtl/cache_port_arbiter_if.sv
// Bundle of signals between the IF/MEM request ports, the shared data
// cache and the arbiter that sequences accesses to it.
//
// Request handshake: a requester raises req_x with its fields and holds
// req_x until it sees ack_x. ack_x is a one-cycle pulse. The requester
// drops req_x, or presents a new request, on the edge where it observes
// ack_x. Fields are latched at grant time, so later changes are ignored.
// Cache side: cache_ren/cache_wen are one-cycle strobes. cache_dataout and
// cache_miss are valid in the cycle after a strobe.
interface cache_port_arbiter_if;
  // instruction fetch port (read-only)
  logic        req_i;
  logic [31:0] addr_i;
  logic        ack_i;
  // load/store port
  logic        req_d;
  logic        wen_d;
  logic [31:0] addr_d;
  logic [31:0] wdata_d;
  logic [3:0]  bsel_d;
  logic        ack_d;
  // shared response / status
  logic [31:0] rdata;
  logic        busy;
  logic [15:0] miss_cnt;
  // cache side
  logic        cache_ren;
  logic        cache_wen;
  logic [31:0] cache_addr;
  logic [31:0] cache_old_addr;
  logic [31:0] cache_wdata;
  logic [3:0]  cache_bsel;
  logic [31:0] cache_dataout;
  logic        cache_miss;
  // sequencer state for observation
  logic [2:0]  dbg_state;

  // arbiter side
  modport slave (
    input  req_i, addr_i,
    input  req_d, wen_d, addr_d, wdata_d, bsel_d,
    input  cache_dataout, cache_miss,
    output ack_i, ack_d, rdata, busy, miss_cnt,
    output cache_ren, cache_wen, cache_addr, cache_old_addr,
    output cache_wdata, cache_bsel, dbg_state
  );

  // pipeline + cache side
  modport master (
    output req_i, addr_i,
    output req_d, wen_d, addr_d, wdata_d, bsel_d,
    output cache_dataout, cache_miss,
    input  ack_i, ack_d, rdata, busy, miss_cnt,
    input  cache_ren, cache_wen, cache_addr, cache_old_addr,
    input  cache_wdata, cache_bsel, dbg_state
  );
endinterface

// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter and access sequencer for the single-ported data
// cache shared by instruction fetch and load/store. One transaction at a
// time: grant, one-cycle strobe, response check, optional refill window,
// one-cycle acknowledge. Every output comes straight from a register.
module cache_port_arbiter #(
  parameter int REFILL_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  cache_port_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    RESP   = 3'd2,
    REFILL = 3'd3,
    ACK    = 3'd4
  } state_t;

  // refill counter starts one below the cycle count so the counter hits 0
  // in the last REFILL cycle
  localparam logic [3:0] REFILL_LOAD = 4'(REFILL_CYCLES - 1);

  state_t      state;
  logic        gnt_d;       // 1: data port owns the current transaction
  logic        last_gnt_d;  // 1: data port was granted last
  logic        wen_q;       // current transaction is a store
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  bsel_q;
  logic [31:0] rdata_q;
  logic [15:0] miss_cnt_q;
  logic [3:0]  refill_ctr;
  logic        ren_q;
  logic        wen_strobe_q;
  logic        ack_i_q;
  logic        ack_d_q;
  logic        busy_q;
  logic        pick_d;

  // Grant choice for IDLE: a lone requester wins; on a tie the port that
  // was not granted last wins.
  always_comb begin
    pick_d = bus.req_d && (!bus.req_i || !last_gnt_d);
  end

  // Sequencer: state, latched request fields and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      gnt_d        <= 1'b0;
      last_gnt_d   <= 1'b1;
      wen_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      bsel_q       <= '0;
      rdata_q      <= '0;
      miss_cnt_q   <= '0;
      refill_ctr   <= '0;
      ren_q        <= 1'b0;
      wen_strobe_q <= 1'b0;
      ack_i_q      <= 1'b0;
      ack_d_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      // strobes and acks are single-cycle pulses
      ren_q        <= 1'b0;
      wen_strobe_q <= 1'b0;
      ack_i_q      <= 1'b0;
      ack_d_q      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.req_i || bus.req_d) begin
            gnt_d      <= pick_d;
            last_gnt_d <= pick_d;
            if (pick_d) begin
              wen_q        <= bus.wen_d;
              addr_q       <= bus.addr_d;
              wdata_q      <= bus.wdata_d;
              bsel_q       <= bus.bsel_d;
              ren_q        <= !bus.wen_d;
              wen_strobe_q <= bus.wen_d;
            end else begin
              // instruction fetches never write: zero the store fields
              wen_q   <= 1'b0;
              addr_q  <= bus.addr_i;
              wdata_q <= '0;
              bsel_q  <= '0;
              ren_q   <= 1'b1;
            end
            busy_q <= 1'b1;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          state <= RESP;
        end
        RESP: begin
          if (bus.cache_miss) begin
            if (miss_cnt_q != 16'hFFFF) begin
              miss_cnt_q <= miss_cnt_q + 16'd1;
            end
            refill_ctr <= REFILL_LOAD;
            state      <= REFILL;
          end else begin
            if (!wen_q) begin
              rdata_q <= bus.cache_dataout;
            end
            ack_i_q <= !gnt_d;
            ack_d_q <= gnt_d;
            state   <= ACK;
          end
        end
        REFILL: begin
          if (refill_ctr == 4'd0) begin
            if (wen_q) begin
              // the cache allocates on a write miss: the store is done
              ack_d_q <= gnt_d;
              ack_i_q <= !gnt_d;
              state   <= ACK;
            end else begin
              // reads retry the same address after the line arrives
              ren_q <= 1'b1;
              state <= ISSUE;
            end
          end else begin
            refill_ctr <= refill_ctr - 4'd1;
          end
        end
        ACK: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // Output map: everything is a register or a latched field.
  assign bus.ack_i          = ack_i_q;
  assign bus.ack_d          = ack_d_q;
  assign bus.rdata          = rdata_q;
  assign bus.busy           = busy_q;
  assign bus.miss_cnt       = miss_cnt_q;
  assign bus.cache_ren      = ren_q;
  assign bus.cache_wen      = wen_strobe_q;
  assign bus.cache_addr     = addr_q;
  assign bus.cache_old_addr = addr_q;
  assign bus.cache_wdata    = wdata_q;
  assign bus.cache_bsel     = bsel_q;
  assign bus.dbg_state      = state;

  // Strobes never overlap and at most one port is acknowledged.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(ren_q && wen_strobe_q))
        else $error("cache_ren and cache_wen both high");
      assert (!(ack_i_q && ack_d_q))
        else $error("ack_i and ack_d both high");
    end
  end

endmodule
